// File: rtl/unified_mem_arbiter_pkg.sv
// Shared types for the unified I/D memory arbiter.
// Address/data widths default to the core-wide sizes.
`ifndef ADDR_SIZE
`define ADDR_SIZE 32
`endif
`ifndef DATA_SIZE
`define DATA_SIZE 32
`endif
`ifndef INST_SIZE
`define INST_SIZE `DATA_SIZE
`endif

package unified_mem_arbiter_pkg;

    typedef enum logic [2:0] {
        IDLE,
        BUSY_IF,
        BUSY_DM,
        RESP_IF,
        RESP_DM
    } arb_state_t;

    typedef enum logic {
        OWN_IF,
        OWN_DM
    } arb_owner_t;

    localparam int unsigned STARVE_MAX_DEF = 4;
    localparam int unsigned STARVE_CNT_W   = 4;

endpackage

// File: rtl/unified_mem_arbiter_starve_counter.sv
// Saturating count of data grants taken while a fetch waits.
// at_max_o tells the arbiter that fetch must win next.
module arb_starve_counter
    import unified_mem_arbiter_pkg::*;
#(
    parameter int unsigned MAX = STARVE_MAX_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic inc_i,
    output logic at_max_o
);

    localparam logic [STARVE_CNT_W-1:0] MAX_C = STARVE_CNT_W'(MAX);

    logic [STARVE_CNT_W-1:0] cnt_q;
    logic [STARVE_CNT_W-1:0] cnt_d;

    // Clear wins over increment; increment stops at MAX.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != MAX_C)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_max_o = (cnt_q == MAX_C);

endmodule

// File: rtl/unified_mem_arbiter.sv
// Arbitrates one single-port memory between fetch and load/store.
// Data has priority; a starvation counter forces fetch through.
module unified_mem_arbiter
    import unified_mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W     = `ADDR_SIZE,
    parameter int unsigned DATA_W     = `DATA_SIZE,
    parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic              if_ready,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_ready,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_state_t        state_q, state_d;
    logic              drop_q, drop_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;

    logic       grant;
    arb_owner_t owner;
    logic       at_max;
    logic       in_idle;
    logic       cnt_clr;
    logic       cnt_inc;

    assign in_idle = (state_q == IDLE);

    // Pick the winner of an IDLE-cycle arbitration.
    always_comb begin
        grant = 1'b0;
        owner = OWN_DM;
        if (if_req && !if_flush && (!dm_req || at_max)) begin
            grant = 1'b1;
            owner = OWN_IF;
        end else if (dm_req) begin
            grant = 1'b1;
            owner = OWN_DM;
        end
    end

    assign cnt_clr = in_idle && grant && ((owner == OWN_IF) || !if_req);
    assign cnt_inc = in_idle && grant && (owner == OWN_DM) && if_req;

    arb_starve_counter #(
        .MAX (STARVE_MAX)
    ) u_starve (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (cnt_clr),
        .inc_i    (cnt_inc),
        .at_max_o (at_max)
    );

    // Next state, memory-side registers and read-data capture.
    always_comb begin
        state_d     = state_q;
        drop_d      = drop_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        unique case (state_q)
            IDLE: begin
                drop_d = 1'b0;
                if (grant) begin
                    mem_req_d = 1'b1;
                    if (owner == OWN_IF) begin
                        mem_we_d    = 1'b0;
                        mem_addr_d  = if_addr;
                        mem_wdata_d = '0;
                        state_d     = BUSY_IF;
                    end else begin
                        mem_we_d    = dm_we;
                        mem_addr_d  = dm_addr;
                        mem_wdata_d = dm_wdata;
                        state_d     = BUSY_DM;
                    end
                end
            end
            BUSY_IF: begin
                if (if_flush) begin
                    drop_d = 1'b1;
                end
                if (mem_ack) begin
                    if_rdata_d  = mem_rdata;
                    mem_req_d   = 1'b0;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = '0;
                    mem_wdata_d = '0;
                    state_d     = RESP_IF;
                end
            end
            BUSY_DM: begin
                if (mem_ack) begin
                    if (!mem_we_q) begin
                        dm_rdata_d = mem_rdata;
                    end
                    mem_req_d   = 1'b0;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = '0;
                    mem_wdata_d = '0;
                    state_d     = RESP_DM;
                end
            end
            RESP_IF: begin
                drop_d  = 1'b0;
                state_d = IDLE;
            end
            RESP_DM: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers, synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            drop_q      <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            drop_q      <= drop_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
        end
    end

    assign if_ready  = (state_q == RESP_IF) && !drop_q && !if_flush;
    assign dm_ready  = (state_q == RESP_DM);
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Scoreboard bench for unified_mem_arbiter.
// Random fetch/load/store traffic against a memory model.
module tb_unified_mem_arbiter;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int SMAX = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic          if_flush = 1'b0;
    logic          if_ready;
    logic [DW-1:0] if_rdata;
    logic          dm_req = 1'b0;
    logic          dm_we = 1'b0;
    logic [AW-1:0] dm_addr = '0;
    logic [DW-1:0] dm_wdata = '0;
    logic          dm_ready;
    logic [DW-1:0] dm_rdata;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ack = 1'b0;
    logic [DW-1:0] mem_rdata = '0;

    always #5 clk = ~clk;

    unified_mem_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_ready(if_ready), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_ready(dm_ready), .dm_rdata(dm_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Memory contents: smem is the slave's storage, rmem the reference view.
    logic [31:0] smem [logic [31:0]];
    logic [31:0] rmem [logic [31:0]];

    function automatic logic [31:0] hashv(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] rd_ref(input logic [31:0] a);
        return rmem.exists(a) ? rmem[a] : hashv(a);
    endfunction

    typedef struct {
        logic        we;
        logic [31:0] data;
    } dm_exp_t;

    logic [31:0] if_q [$];
    dm_exp_t     dm_q [$];

    // Memory slave: acks after fixed_lat (or random) extra busy cycles.
    int fixed_lat = -1;
    bit slave_en  = 1'b1;

    initial begin
        bit busy;
        int wn;
        busy = 1'b0;
        wn   = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!slave_en) begin
                busy = 1'b0;
                continue;
            end
            mem_ack   = 1'b0;
            mem_rdata = $urandom;
            if (!rst_n) begin
                busy = 1'b0;
                continue;
            end
            if (mem_req && !busy) begin
                busy = 1'b1;
                wn = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
            end
            if (busy) begin
                if (wn == 0) begin
                    mem_ack = 1'b1;
                    busy    = 1'b0;
                    if (mem_we) smem[mem_addr] = mem_wdata;
                    else mem_rdata = smem.exists(mem_addr) ?
                                     smem[mem_addr] : hashv(mem_addr);
                end else begin
                    wn--;
                end
            end
        end
    end

    // Monitor: ready scoreboard, grant order and memory-port rules.
    logic        p_if_req = 0, p_flush = 0, p_dm_req = 0, p_dm_we = 0;
    logic [31:0] p_if_addr = 0, p_dm_addr = 0, p_dm_wdata = 0;
    logic        p_mreq = 0, p_mwe = 0;
    logic [31:0] p_maddr = 0, p_mwdata = 0;
    int          streak = 0;
    bit          glog [$];
    int          if_pulses = 0;
    int          dm_pulses = 0;
    int          busy_cnt = 0;

    initial begin
        dm_exp_t e;
        bit      fw;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                streak = 0;
                p_mreq = 1'b0;
            end else begin
                chk("ready_exclusive", if_ready & dm_ready, 1'b0);
                if (if_ready) begin
                    if_pulses++;
                    if (if_q.size() == 0) chk("if_ready_unexpected", if_ready, 1'b0);
                    else chk("if_rdata", if_rdata, if_q.pop_front());
                end
                if (dm_ready) begin
                    dm_pulses++;
                    if (dm_q.size() == 0) chk("dm_ready_unexpected", dm_ready, 1'b0);
                    else begin
                        e = dm_q.pop_front();
                        if (!e.we) chk("dm_rdata", dm_rdata, e.data);
                    end
                end
                if (mem_req && !p_mreq) begin
                    fw = p_if_req && !p_flush && (!p_dm_req || streak == SMAX);
                    busy_cnt = 1;
                    if (fw) begin
                        chk("gnt_if_addr", mem_addr, p_if_addr);
                        chk("gnt_if_we", mem_we, 1'b0);
                        chk("gnt_if_wdata", mem_wdata, 0);
                        streak = 0;
                        glog.push_back(1'b1);
                    end else begin
                        chk("gnt_dm_req", p_dm_req, 1'b1);
                        chk("gnt_dm_addr", mem_addr, p_dm_addr);
                        chk("gnt_dm_we", mem_we, p_dm_we);
                        chk("gnt_dm_wdata", mem_wdata, p_dm_wdata);
                        streak = !p_if_req ? 0 : (streak >= SMAX ? SMAX : streak + 1);
                        glog.push_back(1'b0);
                    end
                end else if (mem_req) begin
                    busy_cnt++;
                    chk("hold_addr", mem_addr, p_maddr);
                    chk("hold_we", mem_we, p_mwe);
                    chk("hold_wdata", mem_wdata, p_mwdata);
                end else begin
                    chk("idle_mem_zero", {mem_we, mem_addr, mem_wdata}, 0);
                end
                p_mreq   = mem_req;
                p_mwe    = mem_we;
                p_maddr  = mem_addr;
                p_mwdata = mem_wdata;
            end
            p_if_req   = if_req;
            p_flush    = if_flush;
            p_if_addr  = if_addr;
            p_dm_req   = dm_req;
            p_dm_we    = dm_we;
            p_dm_addr  = dm_addr;
            p_dm_wdata = dm_wdata;
        end
    end

    // Fetch requester; flush_at<0 means never flush. Called at posedge+1.
    task automatic do_fetch(input logic [31:0] a, input int flush_at,
                            output int lat);
        int n;
        n   = 0;
        lat = -1;
        if_q.push_back(rd_ref(a));
        if_req  = 1'b1;
        if_addr = a;
        forever begin
            if (n == flush_at) begin
                if_flush = 1'b1;
                void'(if_q.pop_back());
            end
            @(negedge clk);
            if (n == flush_at) begin
                @(posedge clk);
                #1;
                if_flush = 1'b0;
                if_req   = 1'b0;
                return;
            end
            if (if_ready) begin
                lat = n;
                break;
            end
            n++;
            if (n > 200) begin
                chk("if_ready_timeout", if_ready, 1'b1);
                if (if_q.size() > 0) void'(if_q.pop_back());
                break;
            end
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        if_req = 1'b0;
    endtask

    // Load/store requester. Called at posedge+1.
    task automatic do_dm(input logic we, input logic [31:0] a,
                         input logic [31:0] wd, output int lat);
        dm_exp_t e;
        int n;
        n      = 0;
        lat    = -1;
        e.we   = we;
        e.data = we ? 32'h0 : rd_ref(a);
        if (we) rmem[a] = wd;
        dm_q.push_back(e);
        dm_req   = 1'b1;
        dm_we    = we;
        dm_addr  = a;
        dm_wdata = wd;
        forever begin
            @(negedge clk);
            if (dm_ready) begin
                lat = n;
                break;
            end
            n++;
            if (n > 200) begin
                chk("dm_ready_timeout", dm_ready, 1'b1);
                if (dm_q.size() > 0) void'(dm_q.pop_back());
                break;
            end
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        dm_req = 1'b0;
        dm_we  = 1'b0;
    endtask

    initial begin
        int l, l1, l2, l3, f1, f2, ip0, dp0;
        smem[32'h4]    = 32'h0050_0093;
        rmem[32'h4]    = 32'h0050_0093;
        smem[32'h8200] = 32'h0000_DEAD;
        rmem[32'h8200] = 32'h0000_DEAD;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_outputs",
            {if_ready, dm_ready, mem_req, mem_we, mem_addr, mem_wdata}, 0);
        chk("reset_rdata", {if_rdata, dm_rdata}, 0);
        @(posedge clk);
        #1;

        fixed_lat = 1;
        do_fetch(32'h4, -1, l);
        chk("fetch_latency", l, 3);
        fixed_lat = 0;
        do_dm(1'b0, 32'h14, 32'h0, l);
        chk("dm_min_latency", l, 2);

        glog.delete();
        fork
            do_fetch(32'h8000, -1, l1);
            do_dm(1'b0, 32'h10, 32'h0, l2);
        join
        chk("contention_first_dm", glog[0], 1'b0);
        chk("contention_then_if", glog[1], 1'b1);

        glog.delete();
        fork
            begin
                do_fetch(32'h8100, -1, l1);
                do_fetch(32'h8104, -1, l1);
            end
            for (int i = 0; i < 10; i++) do_dm(1'b0, 32'h40 + 4 * i, 32'h0, l3);
        join
        f1 = -1;
        f2 = -1;
        foreach (glog[i]) begin
            if (glog[i] && f1 < 0) f1 = i;
            else if (glog[i] && f2 < 0) f2 = i;
        end
        chk("starve_first_if", f1, 4);
        chk("starve_second_if", f2, 9);

        fixed_lat = 3;
        ip0 = if_pulses;
        do_fetch(32'h8200, 2, l);
        repeat (6) @(posedge clk);
        #1;
        chk("flush_no_ready", if_pulses, ip0);
        chk("flush_rdata_updated", if_rdata, 32'h0000_DEAD);
        do_fetch(32'h8204, -1, l);
        chk("after_flush_latency", l, 5);

        fixed_lat = 5;
        do_dm(1'b1, 32'h8, 32'h55, l);
        chk("slow_store_latency", l, 7);
        chk("slow_busy_cycles", busy_cnt, 6);
        chk("store_written", smem[32'h8], 32'h55);
        fixed_lat = 0;
        do_dm(1'b0, 32'h8, 32'h0, l);

        slave_en = 1'b0;
        mem_ack  = 1'b0;
        dm_req   = 1'b1;
        dm_we    = 1'b1;
        dm_addr  = 32'h200;
        dm_wdata = 32'h77;
        @(posedge clk);
        #1;
        rst_n  = 1'b0;
        dm_req = 1'b0;
        dm_we  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_busy_outputs",
            {if_ready, dm_ready, mem_req, mem_we, mem_addr, mem_wdata}, 0);
        chk("rst_busy_rdata", {if_rdata, dm_rdata}, 0);
        ip0 = if_pulses;
        dp0 = dm_pulses;
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        mem_ack   = 1'b1;
        mem_rdata = 32'hBAD0_BAD0;
        @(posedge clk);
        #1;
        mem_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("stray_ack_no_ready", if_pulses + dm_pulses, ip0 + dp0);
        chk("stray_ack_no_req", mem_req, 1'b0);
        slave_en  = 1'b1;
        fixed_lat = -1;

        fork
            for (int i = 0; i < 120; i++) begin
                int fl;
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
                fl = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 4)) : -1;
                do_fetch(32'h8000 + 4 * $urandom_range(0, 255), fl, l1);
            end
            for (int i = 0; i < 120; i++) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
                do_dm(1'($urandom_range(0, 1)), 32'h100 + 4 * $urandom_range(0, 15),
                      $urandom, l2);
            end
        join
        repeat (4) @(posedge clk);
        #1;
        chk("if_queue_drained", if_q.size(), 0);
        chk("dm_queue_drained", dm_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/unified_mem_arbiter.md
# unified_mem_arbiter

Shares one single-port unified instruction/data memory between the IF stage (instruction fetch) and the MEM stage (load/store) of the 5-stage pipeline. Data accesses have priority, and a starvation counter guarantees that fetch eventually wins. A fetch can be flushed on a taken branch without aborting the memory transaction already in flight. Each requester sees a req/ready handshake; the pipeline stall logic stalls whichever stage is waiting.

## Interface
Parameters:
- ADDR_W, default `ADDR_SIZE: memory address width
- DATA_W, default `DATA_SIZE: memory word width; also the instruction width (`INST_SIZE` must equal `DATA_SIZE`)
- STARVE_MAX, default 4: maximum consecutive data grants while fetch waits; legal range 1..15

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst_n  input  1  reset; synchronous, active-low
- if_req  input  1  fetch request; held with if_addr stable until if_ready
- if_addr  input  ADDR_W  fetch address
- if_flush  input  1  taken branch; abandons the current fetch
- if_ready  output  1  one-cycle pulse: if_rdata valid
- if_rdata  output  DATA_W  fetched instruction
- dm_req  input  1  data request; held with dm_we/dm_addr/dm_wdata stable until dm_ready
- dm_we  input  1  1 = store, 0 = load
- dm_addr  input  ADDR_W  data address
- dm_wdata  input  DATA_W  store data
- dm_ready  output  1  one-cycle pulse: access complete; dm_rdata valid for loads
- dm_rdata  output  DATA_W  load data
- mem_req  output  1  memory access active
- mem_we  output  1  memory write enable
- mem_addr  output  ADDR_W  memory address
- mem_wdata  output  DATA_W  memory write data
- mem_ack  input  1  memory completion; mem_rdata valid this cycle
- mem_rdata  input  DATA_W  memory read data

## Operation
States are IDLE, BUSY_IF, BUSY_DM, RESP_IF and RESP_DM.

- **IDLE:** arbitrate.
  - dm_req wins, unless if_req=1 and starve_cnt==STARVE_MAX; then fetch wins.
  - A fetch is granted only if if_flush=0.
  - With no request, stay in IDLE.
- **Grant:** register mem_addr, mem_we (dm_we for a data grant, 0 for a fetch) and mem_wdata (dm_wdata or 0). Assert mem_req and go to BUSY_IF or BUSY_DM.
- **BUSY_x:**
  - Hold mem_req and all mem_* outputs stable.
  - On mem_ack=1, drop mem_req next cycle and go to RESP_x.
  - On ack, capture mem_rdata into if_rdata (BUSY_IF) or into dm_rdata (BUSY_DM, load only).
- **RESP_x:**
  - Pulse the corresponding ready for exactly one cycle, then go to IDLE.
  - RESP_x never arbitrates; the requester presents a new request from the cycle after ready.
- **Flush:**
  - if_flush=1 in BUSY_IF sets a drop flag. The memory transaction still completes and if_rdata is still updated, but if_ready is suppressed in RESP_IF. The flag clears on entering IDLE.
  - if_flush=1 in RESP_IF suppresses that cycle's if_ready.
  - Flush has no effect on data transactions.
- **Starvation counter** (starve_cnt, 4 bits), updated at each grant:
  - fetch grant: cnt=0
  - data grant with if_req=1: cnt=min(cnt+1, STARVE_MAX)
  - data grant with if_req=0: cnt=0
- **Ignored input:** mem_ack is ignored in IDLE and RESP_x.
- **Output hold:** if_rdata and dm_rdata hold their values between captures. dm_rdata is not updated on stores.

## Timing
- **Reset (rst_n=0 at a clock edge):** state=IDLE, starve_cnt=0, drop flag=0, all outputs 0. This applies mid-transaction; a late mem_ack after reset is ignored.
- **Latency:** request seen in IDLE at cycle t → mem_req high from t+1 → ack at cycle a≥t+1 → ready at a+1.
  - Minimum request-to-ready latency is 2 cycles (ack in the first BUSY cycle).
  - Peak throughput is one access per 3 cycles.
- **mem_* outputs:** registered; mem_addr, mem_we and mem_wdata are 0 whenever mem_req=0.
- **ready pulses:** if_ready and dm_ready are never high in the same cycle.

## Structure
- Package unified_mem_arbiter_pkg holds:
  - the state enum typedef, arb_state_t (IDLE, BUSY_IF, BUSY_DM, RESP_IF, RESP_DM)
  - the grant-owner enum, arb_owner_t (OWN_IF, OWN_DM)
  - the default STARVE_MAX constant
- Top module: FSM, address/data registers, read-data capture.
- One sub-module, arb_starve_counter: saturating counter with clear/increment inputs and an at_max output.

## Test plan
- **Single fetch:** if_req=1, if_addr=0x04, mem_ack one cycle after mem_req with rdata=0x00500093 → if_ready pulses 3 cycles after the request, if_rdata=0x00500093.
- **Contention:** if_req=1 and dm_req=1 (load, addr 0x10) in the same cycle → data granted first (mem_addr=0x10, mem_we=0); fetch granted after dm_ready.
- **Starvation:** if_req held, dm_req held continuously, STARVE_MAX=4 → exactly 4 data grants, then a fetch grant, then the counter restarts at 0.
- **Flush in flight:** fetch granted, if_flush=1 in BUSY_IF, ack with rdata=0xDEAD → no if_ready pulse; next grant proceeds normally.
- **Store then reset:** store addr 0x08, wdata 0x55, mem_we=1 held until ack. Separately, rst_n=0 in BUSY_DM → next cycle all outputs 0 and state IDLE; a subsequent stray mem_ack produces no ready.
- **Slow memory:** ack delayed 5 cycles → mem_req, mem_addr and mem_wdata are stable for all 5 cycles, and ready pulses exactly once.
